// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and buffers returned words in a 2-entry FIFO in front of decode.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int DEPTH = 2;

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_pc_d    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_instr_d [DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic [2:0]       occupancy;
    logic [DEPTH-1:0] entry_we;
    logic             unused_target_bits;

    // Low target bits are architecturally ignored; fold them so they are consumed.
    assign unused_target_bits = ^redirect_target[1:0];

    // Output view of the FIFO head; forced to a bubble whenever empty or in reset.
    always_comb begin
        if_valid = ~rst & (count_q != 2'd0);
        if_pc    = 32'd0;
        if_instr = NOP_INSTR;
        if (if_valid) begin
            if_pc    = fifo_pc_q[rd_ptr_q];
            if_instr = fifo_instr_q[rd_ptr_q];
        end
    end

    // Requests are throttled so buffered plus in-flight words never exceed the
    // FIFO depth, which is what makes a push into a full FIFO impossible.
    always_comb begin
        pop       = if_valid & ~stall;
        push      = inflight_q & ~redirect_valid;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = ~rst & (redirect_valid | (occupancy < 3'd2));
        imem_req  = issue;
        imem_addr = redirect_valid ? {redirect_target[31:2], 2'b00} : pc_q;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push & (wr_ptr_q == 1'(gi));
        end
    endgenerate

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;

        if (issue) begin
            pc_d          = imem_addr + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = imem_addr;
        end

        if (redirect_valid) begin
            // Everything buffered or returning this cycle belongs to the old path.
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    fifo_pc_d[i]    = inflight_pc_q;
                    fifo_instr_d[i] = imem_rdata;
                end
            end
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= {RESET_PC[31:2], 2'b00};
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Payload storage needs no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC and drives a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO and presents {pc, instruction, valid} to decode.
- Absorbs decode stalls without losing in-flight words, and accepts redirects for JAL, JALR and taken branches (decode's jump-flush plus the execute branch resolution).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr whenever if_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  32  word-aligned read address; bits[1:0] always 0.
- imem_rdata  in  32  read data; valid exactly one cycle after imem_req=1.
- stall  in  1  decode cannot accept; hold the current head.
- redirect_valid  in  1  single-cycle pulse; discard all fetched and in-flight words.
- redirect_target  in  32  new PC; bits[1:0] are ignored and treated as 0.
- if_valid  out  1  if_pc/if_instr hold a valid fetched instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction encoding.

Behaviour:
- State:
  - pc_q: next fetch address.
  - inflight_q, inflight_pc_q: request issued last cycle and its address.
  - FIFO: 2 entries of {pc, instr}, with rd_ptr, wr_ptr and count 0..2.
- Reset (rst=1 at an edge), regardless of any operation in progress:
  - pc_q=RESET_PC, inflight_q=0, count=0, pointers=0.
  - Outputs while rst=1: imem_req=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR.
- Pop: pop = if_valid & ~stall. The head is consumed at the edge.
- Issue rule (combinational):
  - imem_req = ~rst & (redirect_valid | (count + inflight_q - pop) < 2).
  - imem_addr = redirect_valid ? {redirect_target[31:2],2'b00} : pc_q.
  - When a request issues: pc_q <= imem_addr + 4, inflight_q <= 1, inflight_pc_q <= imem_addr. Otherwise inflight_q <= 0.
- Response: when inflight_q=1 and redirect_valid=0, push {inflight_pc_q, imem_rdata} at the edge. The issue rule guarantees the FIFO is never full at a push.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo 2.
- Outputs (from the FIFO head):
  - if_valid = (count != 0).
  - if_pc and if_instr come from the head entry.
  - When count=0: if_pc=0 and if_instr=NOP_INSTR.
- Stall: the head stays stable while stall=1. Requests continue until count+inflight reaches 2, then imem_req=0 and pc_q holds.
- Redirect, at cycle t:
  - Redirect has priority over stall, push and pop.
  - At the edge: count=0, pointers=0, and the response arriving in cycle t is dropped.
  - A request to the target is issued in cycle t.
  - if_valid=0 in cycle t+1; the target instruction is presented in cycle t+2.
  - The redirect penalty is 2 bubbles.
- Steady state (no stall, no redirect): one instruction per cycle with sequential PCs, steady count=1, inflight=1.
- Reset release:
  - The first cycle with rst=0 requests RESET_PC.
  - if_valid=1 with if_pc=RESET_PC two cycles later.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- No other state exists. There is no exception or misalignment output.

Test Plan:
- Reset then free run (RESET_PC=0, memory word at addr A = A):
  - first if_valid=1 in the 2nd cycle after rst drops, with if_pc=0, if_instr=0.
  - if_pc then reads 4, 8, 12 on consecutive cycles with no bubbles.
- Stall for 5 cycles while presenting pc=8:
  - if_pc=8 held throughout.
  - imem_req drops once count+inflight=2.
  - After release, the next outputs are 8, 12, 16, 20 back to back: no loss, no duplicate.
- Redirect while presenting pc=12 (redirect_target=0x100):
  - next cycle if_valid=0.
  - following cycles show if_pc 0x100, 0x104.
  - The words for 16 and 20 never appear.
- Redirect asserted together with stall=1 and a full FIFO (target 0x40): FIFO flushed, 0x40 presented 2 cycles later.
- Redirect target 0x203: imem_addr=0x200 and if_pc=0x200.
- Assert rst mid-stream (while stalled, FIFO full):
  - next cycle if_valid=0, imem_req=0.
  - After release, fetch restarts at RESET_PC with the same 2-cycle latency.
